player_mask_ctrl: RTL and testbench
===================================

Name: player_mask_ctrl

Overview:
- Upstream of the HUD mask mapper; owns the player's health (mask count) and the HUD placement constants.
- Receives single-cycle damage and heal requests from the game logic, applies invincibility frames after a hit, and runs a timed "focus" heal.
- Handles death and respawn.
- Drives Player_Life, MaskX1/MaskY1/MaskSX/MaskSY and status flags consumed by the mask mapper and the player sprite logic.

Parameters:
- MAX_LIFE, 5, mask count at reset/respawn; legal range 1..15.
- IFRAMES, 60, invincibility duration in frames after a hit.
- HEAL_FRAMES, 45, frames heal_req must be held continuously to gain one mask.
- MASK_X0, 40, HUD centre X of the first mask.
- MASK_Y0, 30, HUD centre Y of the first mask.
- MASK_SX, 12, mask width in pixels.
- MASK_SY, 16, mask height in pixels.

Ports:
- Clk  in  1  system clock (only clock).
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  raw vertical-sync-rate signal; synchronised and rising-edge detected internally.
- hit  in  1  one-Clk pulse: player touched by enemy.
- hit_dmg  in  2  masks removed by this hit (0..3); sampled with hit.
- heal_req  in  1  level: player is holding focus.
- respawn  in  1  one-Clk pulse: leave DEAD.
- Player_Life  out  4  current mask count.
- MaskX1  out  10  HUD first-mask centre X (= MASK_X0).
- MaskY1  out  10  HUD first-mask centre Y (= MASK_Y0).
- MaskSX  out  10  = MASK_SX.
- MaskSY  out  10  = MASK_SY.
- invincible  out  1  high in HURT.
- healing  out  1  high while the heal counter is running.
- dead  out  1  high in DEAD.
- hud_blink  out  1  HUD flash enable (see Optional Feature).

Behaviour:
- Single clock, synchronous active-high reset; no other resets.

Reset values:
- Player_Life = MAX_LIFE; state ALIVE; all counters 0.
- invincible, healing, dead and hud_blink = 0.
- Mask position/size outputs are constants and are not affected by reset.

Frame tick:
- frame_clk passes through a 2-flop synchroniser, then a rising-edge detector.
- This produces frame_tick, one Clk wide. Latency from the frame_clk edge to frame_tick is 3 Clk.
- All frame counters advance only on frame_tick.

State machine (ALIVE, HURT, DEAD):
- ALIVE, hit with hit_dmg > 0: Player_Life ← max(Player_Life − hit_dmg, 0), registered the next Clk.
  - Result 0 → DEAD.
  - Otherwise → HURT with iframe_cnt = 0, and the heal counter is cleared.
- ALIVE, hit with hit_dmg = 0: ignored.
- HURT:
  - Hits are ignored.
  - iframe_cnt increments on each frame_tick; when it reaches IFRAMES−1 on a tick → ALIVE.
  - Heal is inhibited.
- DEAD:
  - Player_Life holds 0; hit and heal are ignored.
  - respawn → ALIVE with Player_Life = MAX_LIFE and counters cleared.
- respawn outside DEAD: ignored.

Heal (ALIVE only):
- While heal_req = 1 and Player_Life < MAX_LIFE: healing = 1 and heal_cnt increments on frame_tick.
- When heal_cnt reaches HEAL_FRAMES−1 on a tick: Player_Life += 1 and heal_cnt ← 0. Continued holding heals again.
- heal_req = 0, or Player_Life = MAX_LIFE: heal_cnt ← 0 and healing = 0 (same Clk).

Simultaneous events and boundaries:
- hit and heal completion in the same Clk: the hit wins and the heal increment is discarded.
- hit coincident with frame_tick in ALIVE: the hit is processed; HURT starts at count 0.
- Player_Life never exceeds MAX_LIFE and never underflows (saturating, 4-bit).
- Reset asserted mid-HURT, mid-heal or in DEAD returns to the reset values on the next Clk edge.

Outputs:
- All status outputs are registered or decoded from the registered state.
- Player_Life changes exactly 1 Clk after the causing event.

Optional Feature:
- Macro: HK_MASK_BLINK_EN.
- Defined:
  - In HURT, hud_blink toggles every 4 frame_ticks, starting at 1 on HURT entry.
  - In ALIVE/DEAD, hud_blink = 0.
  - The mapper uses hud_blink to flash the masks.
- Undefined: hud_blink is tied to 0 and the blink counter is not synthesised.

Decomposition:
- Package hk_hud_pkg holds:
  - the state enum (ALIVE, HURT, DEAD) as a 2-bit typedef;
  - the LIFE_W = 4 and COORD_W = 10 width constants;
  - the default HUD constants (MASK_X0/Y0/SX/SY), shared with the mask mapper.
- One sub-module, frame_tick_gen: synchroniser plus rising-edge detector producing frame_tick.

Test Plan:
1. Reset, then idle for 10 frames → Player_Life = 5; invincible, healing, dead = 0; MaskX1 = 40, MaskY1 = 30, MaskSX = 12, MaskSY = 16.
2. hit with hit_dmg = 1 → Player_Life = 4 one Clk later and invincible = 1.
   - A second hit at frame 30 is ignored, so life stays 4.
   - invincible drops after exactly 60 frame_ticks.
3. Life = 2, hit with hit_dmg = 3 → Player_Life = 0 and dead = 1.
   - A heal_req held 100 frames gives no change.
   - A respawn pulse gives Player_Life = 5 and dead = 0.
4. Life = 3, heal_req held 90 frames → life becomes 4 at tick 45 and 5 at tick 90; healing = 1 throughout.
   - Releasing at tick 44 instead gives no gain and healing = 0.
5. Life = 4, hit with dmg 1 in the same Clk that the heal completes → Player_Life = 3 and state HURT.
6. Reset pulse mid-HURT at frame 20 → Player_Life = 5 and invincible = 0 next Clk.
   - With HK_MASK_BLINK_EN defined, a hit gives hud_blink pattern 1,1,1,1,0,0,0,0… per frame_tick.

Source files
------------

// File: rtl/hk_hud_pkg.sv
// Shared HUD definitions for the player mask controller and the mask mapper:
// controller state encoding, datapath widths and the default HUD placement.
package hk_hud_pkg;

   localparam int LIFE_W  = 4;   // mask count width (0..15)
   localparam int COORD_W = 10;  // HUD pixel coordinate width

   // Default HUD placement of the mask row
   localparam int MASK_X0 = 40;  // centre X of the first mask
   localparam int MASK_Y0 = 30;  // centre Y of the first mask
   localparam int MASK_SX = 12;  // mask width in pixels
   localparam int MASK_SY = 16;  // mask height in pixels

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      HURT  = 2'd1,
      DEAD  = 2'd2
   } state_e;

endpackage : hk_hud_pkg

// File: rtl/frame_tick_gen.sv
// Frame tick generator: brings the raw vertical-sync-rate frame_clk into the
// Clk domain with a 2-flop synchroniser and emits a one-Clk frame_tick on each
// rising edge. The tick is registered, so it appears 3 Clk after the edge.
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic frame_tick
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic tick_q;

   // Synchronise frame_clk and register a pulse on its rising edge
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, independent of statement order.
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= frame_clk;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         tick_q  <= sync2_q & ~prev_q;
      end
   end

   assign frame_tick = tick_q;

endmodule : frame_tick_gen

// File: rtl/player_mask_ctrl.sv
// Player mask controller: owns the player's mask count, applies damage with
// invincibility frames, runs the timed focus heal and handles death/respawn.
// Also publishes the constant HUD placement consumed by the mask mapper.
// Optional HUD flashing during invincibility is enabled by defining
// HK_MASK_BLINK_EN; without it hud_blink is tied low.
module player_mask_ctrl #(
   parameter int MAX_LIFE    = 5,                   // 1..15
   parameter int IFRAMES     = 60,
   parameter int HEAL_FRAMES = 45,
   parameter int MASK_X0     = hk_hud_pkg::MASK_X0,
   parameter int MASK_Y0     = hk_hud_pkg::MASK_Y0,
   parameter int MASK_SX     = hk_hud_pkg::MASK_SX,
   parameter int MASK_SY     = hk_hud_pkg::MASK_SY
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_clk,
   input  logic                           hit,
   input  logic [1:0]                     hit_dmg,
   input  logic                           heal_req,
   input  logic                           respawn,
   output logic [hk_hud_pkg::LIFE_W-1:0]  Player_Life,
   output logic [hk_hud_pkg::COORD_W-1:0] MaskX1,
   output logic [hk_hud_pkg::COORD_W-1:0] MaskY1,
   output logic [hk_hud_pkg::COORD_W-1:0] MaskSX,
   output logic [hk_hud_pkg::COORD_W-1:0] MaskSY,
   output logic                           invincible,
   output logic                           healing,
   output logic                           dead,
   output logic                           hud_blink
);

   import hk_hud_pkg::*;

   localparam int IFR_W  = $clog2(IFRAMES + 1);
   localparam int HEAL_W = $clog2(HEAL_FRAMES + 1);

   localparam logic [LIFE_W-1:0] LIFE_MAX  = LIFE_W'(MAX_LIFE);
   localparam logic [IFR_W-1:0]  IFR_LAST  = IFR_W'(IFRAMES - 1);
   localparam logic [HEAL_W-1:0] HEAL_LAST = HEAL_W'(HEAL_FRAMES - 1);

   logic frame_tick;

   frame_tick_gen u_frame_tick_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   state_e              state_q,   state_d;
   logic [LIFE_W-1:0]   life_q,    life_d;
   logic [IFR_W-1:0]    iframe_q,  iframe_d;
   logic [HEAL_W-1:0]   heal_q,    heal_d;
   logic                healing_q, healing_d;

   logic                hit_valid;
   logic [LIFE_W-1:0]   dmg_ext;

   assign hit_valid = hit && (hit_dmg != 2'd0);
   assign dmg_ext   = {{(LIFE_W-2){1'b0}}, hit_dmg};

   // Next-state: damage has priority over a heal completing in the same Clk
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      life_d   = life_q;
      iframe_d = iframe_q;
      heal_d   = heal_q;

      case (state_q)
         ALIVE: begin
            if (hit_valid) begin
               heal_d   = '0;
               iframe_d = '0;
               if (life_q <= dmg_ext) begin
                  life_d  = '0;
                  state_d = DEAD;
               end else begin
                  life_d  = life_q - dmg_ext;
                  state_d = HURT;
               end
            end else if (heal_req && (life_q < LIFE_MAX)) begin
               if (frame_tick) begin
                  if (heal_q == HEAL_LAST) begin
                     life_d = life_q + LIFE_W'(1);
                     heal_d = '0;
                  end else begin
                     heal_d = heal_q + HEAL_W'(1);
                  end
               end
            end else begin
               heal_d = '0;
            end
         end

         HURT: begin
            heal_d = '0;
            if (frame_tick) begin
               if (iframe_q == IFR_LAST) begin
                  iframe_d = '0;
                  state_d  = ALIVE;
               end else begin
                  iframe_d = iframe_q + IFR_W'(1);
               end
            end
         end

         DEAD: begin
            life_d   = '0;
            heal_d   = '0;
            iframe_d = '0;
            if (respawn) begin
               life_d  = LIFE_MAX;
               state_d = ALIVE;
            end
         end

         default: begin
            state_d  = ALIVE;
            life_d   = LIFE_MAX;
            iframe_d = '0;
            heal_d   = '0;
         end
      endcase

      healing_d = (state_q == ALIVE) && (state_d == ALIVE) && heal_req &&
                  (life_d < LIFE_MAX);
   end

   // State, life, counters and healing flag register; reset restores full health
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ALIVE;
         life_q    <= LIFE_MAX;
         iframe_q  <= '0;
         heal_q    <= '0;
         healing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         life_q    <= life_d;
         iframe_q  <= iframe_d;
         heal_q    <= heal_d;
         healing_q <= healing_d;
      end
   end

`ifdef HK_MASK_BLINK_EN
   logic [1:0] blink_cnt_q;
   logic       blink_q;

   // HUD flash: starts lit on HURT entry, toggles every 4 frame ticks in HURT
   always_ff @(posedge Clk) begin
      if (Reset) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else if (state_d != HURT) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else if (state_q != HURT) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else if (frame_tick) begin
         blink_cnt_q <= blink_cnt_q + 2'd1;
         if (blink_cnt_q == 2'd3) begin
            blink_q <= ~blink_q;
         end
      end
   end

   assign hud_blink = blink_q;
`else
   assign hud_blink = 1'b0;
`endif

   assign Player_Life = life_q;
   assign invincible  = (state_q == HURT);
   assign dead        = (state_q == DEAD);
   assign healing     = healing_q;

   assign MaskX1 = COORD_W'(MASK_X0);
   assign MaskY1 = COORD_W'(MASK_Y0);
   assign MaskSX = COORD_W'(MASK_SX);
   assign MaskSY = COORD_W'(MASK_SY);

endmodule : player_mask_ctrl

// File: tb/tb_player_mask_ctrl.sv
// Self-checking bench for player_mask_ctrl. A behavioural model of life, state
// and frame counters produces expected output vectors, pushed to a scoreboard
// queue when stimulus is applied and popped when the DUT output is compared.
// Observed vector: {Player_Life[3:0], invincible, healing, dead, hud_blink}.
module tb_player_mask_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       hit;
   logic [1:0] hit_dmg;
   logic       heal_req;
   logic       respawn;
   logic [3:0] Player_Life;
   logic [9:0] MaskX1, MaskY1, MaskSX, MaskSY;
   logic       invincible, healing, dead, hud_blink;

   player_mask_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .hit         (hit),
      .hit_dmg     (hit_dmg),
      .heal_req    (heal_req),
      .respawn     (respawn),
      .Player_Life (Player_Life),
      .MaskX1      (MaskX1),
      .MaskY1      (MaskY1),
      .MaskSX      (MaskSX),
      .MaskSY      (MaskSY),
      .invincible  (invincible),
      .healing     (healing),
      .dead        (dead),
      .hud_blink   (hud_blink)
   );

   always #5 Clk = ~Clk;

`ifdef HK_MASK_BLINK_EN
   localparam logic BLINK_ENTRY = 1'b1;
`else
   localparam logic BLINK_ENTRY = 1'b0;
`endif

   typedef enum {M_ALIVE, M_HURT, M_DEAD} mstate_e;
   typedef struct {
      string      name;
      logic [7:0] v;
   } exp_t;

   exp_t    sb[$];
   exp_t    e;
   int      n_run  = 0;
   int      n_fail = 0;

   // Reference model
   int      m_life;
   mstate_e m_state;
   int      m_hurt_ticks;
   int      m_heal_ticks;

   function automatic logic [7:0] obs_vec();
      return {Player_Life, invincible, healing, dead, hud_blink};
   endfunction

   function automatic logic [7:0] exp_vec();
      logic bl;
      bl = 1'b0;
`ifdef HK_MASK_BLINK_EN
      bl = (m_state == M_HURT) && (((m_hurt_ticks / 4) % 2) == 0);
`endif
      return {4'(m_life), (m_state == M_HURT),
              (m_state == M_ALIVE) && heal_req && (m_life < 5),
              (m_state == M_DEAD), bl};
   endfunction

   task automatic clk_n(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic model_reset();
      m_life       = 5;
      m_state      = M_ALIVE;
      m_hurt_ticks = 0;
      m_heal_ticks = 0;
   endtask

   task automatic expect_now(input string nm);
      sb.push_back('{name: nm, v: exp_vec()});
   endtask

   task automatic do_reset();
      Reset = 1'b1; frame_clk = 1'b0; hit = 1'b0; hit_dmg = 2'd0;
      heal_req = 1'b0; respawn = 1'b0;
      clk_n(2);
      Reset = 1'b0;
      model_reset();
      clk_n(1);
   endtask

   // One frame_clk period of 8 Clk; its tick is consumed on the 4th edge
   task automatic frame();
      frame_clk = 1'b1;
      clk_n(4);
      frame_clk = 1'b0;
      clk_n(4);
      if (m_state == M_HURT) begin
         m_hurt_ticks++;
         if (m_hurt_ticks == 60) m_state = M_ALIVE;
      end else if (m_state == M_ALIVE && heal_req && m_life < 5) begin
         m_heal_ticks++;
         if (m_heal_ticks == 45) begin
            m_life++;
            m_heal_ticks = 0;
         end
      end else begin
         m_heal_ticks = 0;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   task automatic set_heal(input logic v);
      heal_req = v;
      if (!v) m_heal_ticks = 0;
   endtask

   task automatic pulse_hit(input int dmg, input string nm);
      if (m_state == M_ALIVE && dmg != 0) begin
         m_heal_ticks = 0;
         if (dmg >= m_life) begin
            m_life  = 0;
            m_state = M_DEAD;
         end else begin
            m_life       = m_life - dmg;
            m_state      = M_HURT;
            m_hurt_ticks = 0;
         end
      end
      hit = 1'b1; hit_dmg = 2'(dmg);
      clk_n(1);
      hit = 1'b0; hit_dmg = 2'd0;
      expect_now(nm);
   endtask

   task automatic pulse_respawn(input string nm);
      if (m_state == M_DEAD) begin
         m_state      = M_ALIVE;
         m_life       = 5;
         m_hurt_ticks = 0;
         m_heal_ticks = 0;
      end
      respawn = 1'b1;
      clk_n(1);
      respawn = 1'b0;
      expect_now(nm);
   endtask

   task automatic reset_pulse(input string nm);
      Reset = 1'b1;
      clk_n(1);
      model_reset();
      expect_now(nm);
   endtask

   task automatic test_reset();
      do_reset();
      expect_now("reset_state");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(10);
      expect_now("reset_idle10");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      n_run++;
      if ({MaskX1, MaskY1, MaskSX, MaskSY} !== {10'd40, 10'd30, 10'd12, 10'd16}) begin
         n_fail++;
         $display("FAIL hud_consts: got %0d/%0d/%0d/%0d expected 40/30/12/16",
                  MaskX1, MaskY1, MaskSX, MaskSY);
      end
   endtask

   task automatic test_hit_iframes();
      do_reset();
      pulse_hit(0, "hit_dmg0_ignored");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      pulse_hit(1, "hit_dmg1");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(29);
      pulse_hit(2, "hit_in_hurt_ignored");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(30);
      expect_now("iframe_tick59");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frame();
      expect_now("iframe_tick60");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
   endtask

   task automatic test_death();
      do_reset();
      pulse_hit(3, "hit_to_2");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(60);
      pulse_hit(3, "hit_to_dead");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      set_heal(1'b1);
      frames(100);
      pulse_hit(1, "dead_heal_hit_ignored");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      set_heal(1'b0);
      pulse_respawn("respawn");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
   endtask

   task automatic test_heal();
      do_reset();
      pulse_hit(2, "heal_setup_hit");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(60);
      pulse_respawn("respawn_alive_ignored");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      set_heal(1'b1);
      clk_n(1);
      expect_now("heal_start");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(44);
      expect_now("heal_tick44");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frame();
      expect_now("heal_tick45");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(45);
      expect_now("heal_tick90_full");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      // Release after 44 ticks: no gain, and the count restarts from zero
      set_heal(1'b0);
      pulse_hit(1, "heal2_setup_hit");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(60);
      set_heal(1'b1);
      frames(44);
      set_heal(1'b0);
      clk_n(1);
      expect_now("heal_release44");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      set_heal(1'b1);
      frame();
      expect_now("heal_restart_tick1");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(44);
      expect_now("heal_restart_tick45");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      set_heal(1'b0);
   endtask

   task automatic test_hit_vs_heal();
      do_reset();
      pulse_hit(1, "coll_setup_hit");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(60);
      set_heal(1'b1);
      frames(44);
      // Hit lands on the same edge that consumes the 45th heal tick
      frame_clk = 1'b1;
      clk_n(3);
      hit = 1'b1; hit_dmg = 2'd1;
      sb.push_back('{name: "hit_vs_heal", v: {4'd3, 1'b1, 1'b0, 1'b0, BLINK_ENTRY}});
      clk_n(1);
      hit = 1'b0; hit_dmg = 2'd0;
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      m_life = 3; m_state = M_HURT; m_hurt_ticks = 0; m_heal_ticks = 0;
      clk_n(3);
      frame_clk = 1'b0;
      clk_n(4);
      set_heal(1'b0);
      frames(59);
      expect_now("coll_iframe59");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frame();
      expect_now("coll_iframe60");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_hit(2, "rst_setup_hit");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(20);
      reset_pulse("reset_mid_hurt");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      Reset = 1'b0;
      pulse_hit(3, "rst_to_2");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(60);
      set_heal(1'b1);
      frames(20);
      reset_pulse("reset_mid_heal");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      Reset = 1'b0;
      set_heal(1'b0);
      pulse_hit(3, "rst_dead_a");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      frames(60);
      pulse_hit(3, "rst_dead_b");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      reset_pulse("reset_in_dead");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      Reset = 1'b0;
      clk_n(1);
   endtask

   task automatic test_blink();
      do_reset();
      pulse_hit(1, "blink_entry");
      e = sb.pop_front(); n_run++;
      if (obs_vec() !== e.v) begin
         n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
      end
      for (int k = 1; k <= 12; k++) begin
         frame();
         expect_now($sformatf("blink_tick%0d", k));
         e = sb.pop_front(); n_run++;
         if (obs_vec() !== e.v) begin
            n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_vec(), e.v);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; hit = 1'b0; hit_dmg = 2'd0;
      heal_req = 1'b0; respawn = 1'b0;
      model_reset();
      test_reset();
      test_hit_iframes();
      test_death();
      test_heal();
      test_hit_vs_heal();
      test_reset_mid();
      test_blink();
      n_run++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_player_mask_ctrl
